// File: rtl/psg_write_ctrl.sv
// CPU write front-end for the SN76489-style register file: byte protocol decode,
// 10-bit tone shadows, READY busy window and noise-LFSR reset pulse.
`timescale 1ns/1ps
module psg_write_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int BUSY_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       wr_n,
  input  logic       ce_n,
  output logic       ready,
  output logic       overrun,
  output logic [2:0] reg_adress,
  output logic [9:0] reg_value,
  output logic       reg_load,
  output logic       noise_reset
);

  // state   | meaning
  // IDLE    | ready, waiting for a synchronised strobe falling edge
  // DECODE  | captured byte decoded, latch/shadow updated, outputs formed
  // WRITE   | reg_load asserted for this single cycle
  // BUSY    | READY low for BUSY_CYCLES cycles
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;
  localparam logic [1:0] ST_BUSY   = 2'd3;

  localparam int CW = (BUSY_CYCLES < 2) ? 1 : $clog2(BUSY_CYCLES);
  localparam logic [CW-1:0] BUSY_LOAD = CW'(BUSY_CYCLES - 1);

  logic [1:0]             state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   strb_prev;
  logic                   event_det;
  logic [7:0]             data_q;
  logic [2:0]             latch_adr;
  logic [9:0]             shadow [0:2];
  logic [CW-1:0]          busy_cnt;

  logic       is_latch;
  logic       is_tone;
  logic [2:0] dec_adr;
  logic [1:0] dec_ch;
  logic [9:0] cur_shadow;
  logic [9:0] tone_new;
  logic [9:0] dec_val;

  // Strobe is the combined active-low enable; sync chain idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '1;
      strb_prev <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], (wr_n | ce_n)};
      strb_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign event_det = strb_prev & ~sync_q[SYNC_STAGES-1];

  always_comb begin
    is_latch   = data_q[7];
    dec_adr    = is_latch ? data_q[6:4] : latch_adr;
    dec_ch     = dec_adr[2:1];
    is_tone    = ~dec_adr[0] && (dec_ch != 2'd3);
    cur_shadow = 10'd0;
    case (dec_ch)
      2'd0:    cur_shadow = shadow[0];
      2'd1:    cur_shadow = shadow[1];
      2'd2:    cur_shadow = shadow[2];
      default: cur_shadow = 10'd0;
    endcase
    // LATCH byte replaces the low nibble, DATA byte the upper six bits.
    tone_new = is_latch ? {cur_shadow[9:4], data_q[3:0]}
                        : {data_q[5:0], cur_shadow[3:0]};
    dec_val  = is_tone ? tone_new : {6'd0, data_q[3:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ready       <= 1'b1;
      overrun     <= 1'b0;
      reg_adress  <= 3'd0;
      reg_value   <= 10'd0;
      reg_load    <= 1'b0;
      noise_reset <= 1'b0;
      data_q      <= 8'd0;
      latch_adr   <= 3'd0;
      shadow[0]   <= 10'd0;
      shadow[1]   <= 10'd0;
      shadow[2]   <= 10'd0;
      busy_cnt    <= '0;
    end else begin
      reg_load    <= 1'b0;
      noise_reset <= 1'b0;
      if (event_det && (state != ST_IDLE))
        overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (event_det) begin
            data_q <= data_in;
            ready  <= 1'b0;
            state  <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          latch_adr <= dec_adr;
          if (is_tone) begin
            case (dec_ch)
              2'd0:    shadow[0] <= tone_new;
              2'd1:    shadow[1] <= tone_new;
              default: shadow[2] <= tone_new;
            endcase
          end
          reg_adress  <= dec_adr;
          reg_value   <= dec_val;
          reg_load    <= 1'b1;
          noise_reset <= (dec_adr == 3'd6);
          state       <= ST_WRITE;
        end
        ST_WRITE: begin
          busy_cnt <= BUSY_LOAD;
          state    <= ST_BUSY;
        end
        default: begin
          if (busy_cnt == '0) begin
            ready <= 1'b1;
            state <= ST_IDLE;
          end else begin
            busy_cnt <= busy_cnt - 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psg_write_ctrl.sv
// Directed bench for psg_write_ctrl: byte decode, load timing, busy window,
// overrun and reset abort, with hand-computed expected values.
`timescale 1ns/1ps
module tb_psg_write_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic       wr_n = 1'b1;
  logic       ce_n = 1'b0;
  logic       ready, overrun, reg_load, noise_reset;
  logic [2:0] reg_adress;
  logic [9:0] reg_value;

  int n_chk = 0;
  int n_fail = 0;
  int load_cnt = 0;
  int noise_cnt = 0;

  psg_write_ctrl #(.SYNC_STAGES(2), .BUSY_CYCLES(32)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_n(wr_n), .ce_n(ce_n),
    .ready(ready), .overrun(overrun), .reg_adress(reg_adress),
    .reg_value(reg_value), .reg_load(reg_load), .noise_reset(noise_reset)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reg_load) load_cnt++;
    if (noise_reset) noise_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int t = 0;
    while (!ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check_val({tag, " ready_timeout"}, ready, 1);
  endtask

  // Drive at a falling edge; with two sync stages the load lands after the 4th rising edge.
  task automatic write_chk(input string tag, input logic [7:0] d, input logic [2:0] ea,
                           input logic [9:0] ev, input logic en);
    int lk = 0;
    int lc0 = load_cnt;
    @(negedge clk);
    data_in = d;
    wr_n = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 3) begin
        check_val({tag, " ready_low"}, ready, 0);
        wr_n = 1'b1;
      end
      if (reg_load) begin
        lk = k;
        check_val({tag, " adr"}, reg_adress, ea);
        check_val({tag, " val"}, reg_value, ev);
        check_val({tag, " noise"}, noise_reset, en);
      end
    end
    check_val({tag, " load_cycle"}, lk, 4);
    check_val({tag, " load_count"}, load_cnt - lc0, 1);
    check_val({tag, " adr_held"}, reg_adress, ea);
    wait_ready(tag);
  endtask

  initial begin
    int lc0;
    repeat (3) @(negedge clk);
    check_val("rst ready", ready, 1);
    check_val("rst overrun", overrun, 0);
    check_val("rst adr", reg_adress, 0);
    check_val("rst val", reg_value, 0);
    check_val("rst load", reg_load, 0);
    check_val("rst noise", noise_reset, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    write_chk("tone_lo", 8'h8E, 3'd0, 10'h00E, 1'b0);
    write_chk("tone_hi", 8'h0F, 3'd0, 10'h0FE, 1'b0);
    write_chk("latch_only", 8'h83, 3'd0, 10'h0F3, 1'b0);
    write_chk("vol3", 8'hF5, 3'd7, 10'h005, 1'b0);
    check_val("noise_none_yet", noise_cnt, 0);
    write_chk("noise", 8'hE6, 3'd6, 10'h006, 1'b1);
    check_val("noise_one_pulse", noise_cnt, 1);

    write_chk("ch1_lo", 8'hA5, 3'd2, 10'h005, 1'b0);
    write_chk("ch1_hi", 8'h52, 3'd2, 10'h125, 1'b0);
    write_chk("vol1_latch", 8'hB0, 3'd3, 10'h000, 1'b0);
    write_chk("vol1_data", 8'h0A, 3'd3, 10'h00A, 1'b0);
    write_chk("ch1_kept", 8'hA5, 3'd2, 10'h125, 1'b0);

    // wr_n low while chip not enabled must be ignored
    lc0 = load_cnt;
    @(negedge clk);
    ce_n = 1'b1; wr_n = 1'b0; data_in = 8'h9F;
    repeat (6) @(negedge clk);
    wr_n = 1'b1;
    @(negedge clk);
    ce_n = 1'b0;
    repeat (4) @(negedge clk);
    check_val("ce_gate loads", load_cnt - lc0, 0);
    check_val("ce_gate ready", ready, 1);
    check_val("overrun_clear", overrun, 0);

    // busy window: second strobe dropped, strobe on the ready-rise cycle accepted
    lc0 = load_cnt;
    @(negedge clk);
    data_in = 8'h90; wr_n = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 3) wr_n = 1'b1;
      if (k == 4) begin
        check_val("busy first adr", reg_adress, 3'd1);
        check_val("busy first val", reg_value, 10'h000);
      end
      if (k == 5) begin data_in = 8'h9F; wr_n = 1'b0; end
      if (k == 8) wr_n = 1'b1;
      if (k == 10) check_val("busy overrun", overrun, 1);
      if (k == 35) begin data_in = 8'h92; wr_n = 1'b0; end
      if (k == 36) check_val("busy ready_N34", ready, 0);
      if (k == 37) check_val("busy ready_N35", ready, 1);
      if (k == 38) begin
        wr_n = 1'b1;
        check_val("edge accept ready_low", ready, 0);
      end
      if (k == 39) begin
        check_val("edge accept load", reg_load, 1);
        check_val("edge accept val", reg_value, 10'h002);
      end
    end
    check_val("busy load_count", load_cnt - lc0, 2);
    wait_ready("busy");
    check_val("overrun sticky", overrun, 1);

    // reset mid-BUSY
    @(negedge clk);
    data_in = 8'h8F; wr_n = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 3) wr_n = 1'b1;
    end
    check_val("midbusy ready_low", ready, 0);
    rst_n = 1'b0;
    #1;
    check_val("midbusy rst ready", ready, 1);
    check_val("midbusy rst overrun", overrun, 0);
    check_val("midbusy rst adr", reg_adress, 0);
    check_val("midbusy rst val", reg_value, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // reset during DECODE aborts the load
    lc0 = load_cnt;
    @(negedge clk);
    data_in = 8'h85; wr_n = 1'b0;
    for (int k = 1; k <= 3; k++) @(negedge clk);
    rst_n = 1'b0; wr_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check_val("abort no_load", load_cnt - lc0, 0);
    check_val("abort ready", ready, 1);
    write_chk("shadow_cleared", 8'h81, 3'd0, 10'h001, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
